// File: rtl/tod_counter_param.sv
// Time-of-day counter (hours:minutes) with a tick prescaler and prioritised multi-channel load.
// Optional alarm compare enabled by macro TOD_COUNTER_ALARM_EN.
module tod_counter_param #(
    parameter int NUM_LOAD = 2,
    parameter int PRESCALE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NUM_LOAD-1:0]   load_valid,
    input  logic [5*NUM_LOAD-1:0] load_hours,
    input  logic [6*NUM_LOAD-1:0] load_minutes,
`ifdef TOD_COUNTER_ALARM_EN
    input  logic                  alarm_set,
    input  logic [4:0]            alarm_hours,
    input  logic [5:0]            alarm_minutes,
    output logic                  alarm_hit,
`endif
    output logic [4:0]            hours,
    output logic [5:0]            minutes,
    output logic                  minute_pulse,
    output logic                  day_wrap,
    output logic                  load_err
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [4:0]  r_hours;
    logic [5:0]  r_minutes;
    logic [15:0] r_prescale;
    logic        r_minute_pulse;
    logic        r_day_wrap;
    logic        r_load_err;

    logic        w_sel_found;
    logic [4:0]  w_sel_hours;
    logic [5:0]  w_sel_minutes;
    logic        w_load_ok;
    logic        w_load_bad;
    logic        w_ps_last;
    logic        w_advance;
    logic [4:0]  w_next_hours;
    logic [5:0]  w_next_minutes;
    logic        w_wrap;

    // Scan from the top down so the lowest-index requesting channel wins.
    always_comb begin
        w_sel_found   = 1'b0;
        w_sel_hours   = '0;
        w_sel_minutes = '0;
        for (int i = NUM_LOAD - 1; i >= 0; i--) begin
            if (load_valid[i]) begin
                w_sel_found   = 1'b1;
                w_sel_hours   = load_hours[5*i +: 5];
                w_sel_minutes = load_minutes[6*i +: 6];
            end
        end
    end

    assign w_load_ok  = w_sel_found && (w_sel_hours <= 5'd23) && (w_sel_minutes <= 6'd59);
    assign w_load_bad = w_sel_found && !w_load_ok;
    assign w_ps_last  = (r_prescale == PS_LAST);
    // A rejected load leaves the tick path untouched.
    assign w_advance  = tick && !w_load_ok && w_ps_last;

    always_comb begin
        w_next_hours   = r_hours;
        w_next_minutes = r_minutes + 6'd1;
        w_wrap         = 1'b0;
        if (r_minutes == 6'd59) begin
            w_next_minutes = '0;
            if (r_hours == 5'd23) begin
                w_next_hours = '0;
                w_wrap       = 1'b1;
            end else begin
                w_next_hours = r_hours + 5'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hours        <= '0;
            r_minutes      <= '0;
            r_prescale     <= '0;
            r_minute_pulse <= 1'b0;
            r_day_wrap     <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_minute_pulse <= 1'b0;
            r_day_wrap     <= 1'b0;
            r_load_err     <= w_load_bad;
            if (w_load_ok) begin
                r_hours    <= w_sel_hours;
                r_minutes  <= w_sel_minutes;
                r_prescale <= '0;
            end else if (tick) begin
                if (w_ps_last) begin
                    r_prescale     <= '0;
                    r_hours        <= w_next_hours;
                    r_minutes      <= w_next_minutes;
                    r_minute_pulse <= 1'b1;
                    r_day_wrap     <= w_wrap;
                end else begin
                    r_prescale <= r_prescale + 16'd1;
                end
            end
        end
    end

`ifdef TOD_COUNTER_ALARM_EN
    logic [4:0] r_alarm_hours;
    logic [5:0] r_alarm_minutes;
    logic       r_alarm_hit;

    // Only tick-driven advances can fire the alarm; loads never do.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_alarm_hours   <= '0;
            r_alarm_minutes <= '0;
            r_alarm_hit     <= 1'b0;
        end else begin
            r_alarm_hit <= w_advance && (w_next_hours == r_alarm_hours)
                                     && (w_next_minutes == r_alarm_minutes);
            if (alarm_set) begin
                r_alarm_hours   <= alarm_hours;
                r_alarm_minutes <= alarm_minutes;
            end
        end
    end

    assign alarm_hit = r_alarm_hit;
`endif

    assign hours        = r_hours;
    assign minutes      = r_minutes;
    assign minute_pulse = r_minute_pulse;
    assign day_wrap     = r_day_wrap;
    assign load_err     = r_load_err;

endmodule

// File: tb/tb_tod_counter_param.sv
// Randomized + directed bench for tod_counter_param; two instances (PRESCALE 1 and 4) share stimulus.
module tb_tod_counter_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic [1:0]  load_valid;
    logic [9:0]  load_hours;
    logic [11:0] load_minutes;
    logic [4:0]  hours_o [2];
    logic [5:0]  minutes_o [2];
    logic        mp_o [2];
    logic        dw_o [2];
    logic        le_o [2];
`ifdef TOD_COUNTER_ALARM_EN
    logic        alarm_set;
    logic [4:0]  alarm_hours;
    logic [5:0]  alarm_minutes;
    logic        ah_o [2];
`endif

    always #5 clock = ~clock;

    tod_counter_param #(.NUM_LOAD(2), .PRESCALE(1)) dut_p1 (
        .clock(clock), .reset(reset), .tick(tick),
        .load_valid(load_valid), .load_hours(load_hours), .load_minutes(load_minutes),
`ifdef TOD_COUNTER_ALARM_EN
        .alarm_set(alarm_set), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .alarm_hit(ah_o[0]),
`endif
        .hours(hours_o[0]), .minutes(minutes_o[0]), .minute_pulse(mp_o[0]),
        .day_wrap(dw_o[0]), .load_err(le_o[0])
    );

    tod_counter_param #(.NUM_LOAD(2), .PRESCALE(4)) dut_p4 (
        .clock(clock), .reset(reset), .tick(tick),
        .load_valid(load_valid), .load_hours(load_hours), .load_minutes(load_minutes),
`ifdef TOD_COUNTER_ALARM_EN
        .alarm_set(alarm_set), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .alarm_hit(ah_o[1]),
`endif
        .hours(hours_o[1]), .minutes(minutes_o[1]), .minute_pulse(mp_o[1]),
        .day_wrap(dw_o[1]), .load_err(le_o[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: time kept as minutes-of-day, prescaler as a plain tick tally.
    int m_time [2];
    int m_pc   [2];
    int e_mp   [2];
    int e_dw   [2];
    int e_le   [2];
    int a_time;
    int e_ah   [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int ps_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_step();
        int sel, h, mi, old_alarm;
        bit ok;
        sel = -1;
        for (int i = 1; i >= 0; i--) if (load_valid[i]) sel = i;
        old_alarm = a_time;
        for (int k = 0; k < 2; k++) begin
            e_mp[k] = 0; e_dw[k] = 0; e_le[k] = 0; e_ah[k] = 0;
            if (reset) begin
                m_time[k] = 0;
                m_pc[k]   = 0;
                continue;
            end
            ok = 0;
            if (sel >= 0) begin
                h  = int'(load_hours[5*sel +: 5]);
                mi = int'(load_minutes[6*sel +: 6]);
                if (h < 24 && mi < 60) begin
                    m_time[k] = h * 60 + mi;
                    m_pc[k]   = 0;
                    ok = 1;
                end else begin
                    e_le[k] = 1;
                end
            end
            if (!ok && tick) begin
                m_pc[k]++;
                if (m_pc[k] == ps_of(k)) begin
                    m_pc[k]   = 0;
                    m_time[k] = (m_time[k] + 1) % 1440;
                    e_mp[k]   = 1;
                    e_dw[k]   = (m_time[k] == 0) ? 1 : 0;
                    e_ah[k]   = (m_time[k] == old_alarm) ? 1 : 0;
                end
            end
        end
`ifdef TOD_COUNTER_ALARM_EN
        if (reset) a_time = 0;
        else if (alarm_set) a_time = int'(alarm_hours) * 60 + int'(alarm_minutes);
`endif
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        model_step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("p%0d_hours", ps_of(k)),   int'(hours_o[k]),   m_time[k] / 60);
            check($sformatf("p%0d_minutes", ps_of(k)), int'(minutes_o[k]), m_time[k] % 60);
            check($sformatf("p%0d_minute_pulse", ps_of(k)), int'(mp_o[k]), e_mp[k]);
            check($sformatf("p%0d_day_wrap", ps_of(k)), int'(dw_o[k]), e_dw[k]);
            check($sformatf("p%0d_load_err", ps_of(k)), int'(le_o[k]), e_le[k]);
`ifdef TOD_COUNTER_ALARM_EN
            check($sformatf("p%0d_alarm_hit", ps_of(k)), int'(ah_o[k]), e_ah[k]);
`endif
        end
    endtask

    task automatic idle();
        reset = 1'b0; tick = 1'b0; load_valid = 2'b00;
`ifdef TOD_COUNTER_ALARM_EN
        alarm_set = 1'b0;
`endif
    endtask

    task automatic load2(input logic [1:0] v, input int h0, input int m0, input int h1, input int m1);
        load_valid   = v;
        load_hours   = {5'(h1), 5'(h0)};
        load_minutes = {6'(m1), 6'(m0)};
    endtask

    initial begin
        int pulses;
        int h0, h1, mi0, mi1;
        a_time = 0;
        for (int k = 0; k < 2; k++) begin m_time[k] = 0; m_pc[k] = 0; end
        load_hours = '0; load_minutes = '0;
`ifdef TOD_COUNTER_ALARM_EN
        alarm_hours = '0; alarm_minutes = '0;
`endif
        idle();
        reset = 1'b1;
        cycle(); cycle();
        check("rst_hours", int'(hours_o[0]), 0);
        check("rst_minutes", int'(minutes_o[0]), 0);
        check("rst_minute_pulse", int'(mp_o[0]), 0);
        idle();

        // 60 ticks at PRESCALE=1 -> 01:00 with 60 strobes
        pulses = 0;
        tick = 1'b1;
        repeat (60) begin cycle(); if (mp_o[0]) pulses++; end
        idle();
        check("r60_pulses", pulses, 60);
        check("r60_hours", int'(hours_o[0]), 1);
        check("r60_minutes", int'(minutes_o[0]), 0);

        // day wrap from 23:59
        load2(2'b01, 23, 59, 0, 0); cycle();
        idle(); tick = 1'b1; cycle(); idle();
        check("wrap_hours", int'(hours_o[0]), 0);
        check("wrap_minutes", int'(minutes_o[0]), 0);
        check("wrap_minute_pulse", int'(mp_o[0]), 1);
        check("wrap_day_wrap", int'(dw_o[0]), 1);

        // channel priority, and load suppressing a tick
        load2(2'b11, 10, 0, 5, 30); cycle(); idle();
        check("prio_hours", int'(hours_o[0]), 10);
        check("prio_minutes", int'(minutes_o[0]), 0);
        load2(2'b10, 10, 0, 5, 30); tick = 1'b1; cycle(); idle();
        check("ch1_hours", int'(hours_o[0]), 5);
        check("ch1_minutes", int'(minutes_o[0]), 30);
        check("ch1_no_pulse", int'(mp_o[0]), 0);

        // bad load alongside a tick
        load2(2'b01, 12, 0, 0, 0); cycle(); idle();
        load2(2'b01, 24, 10, 0, 0); tick = 1'b1; cycle(); idle();
        check("bad_load_err", int'(le_o[0]), 1);
        check("bad_hours", int'(hours_o[0]), 12);
        check("bad_minutes", int'(minutes_o[0]), 1);
        cycle();
        check("bad_err_clears", int'(le_o[0]), 0);

        // PRESCALE=4: partial count discarded by reset
        reset = 1'b1; cycle(); idle();
        tick = 1'b1; repeat (3) cycle(); idle();
        check("p4_pre_reset", int'(minutes_o[1]), 0);
        reset = 1'b1; cycle(); idle();
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cycle();
            check($sformatf("p4_tick%0d", i + 1), int'(minutes_o[1]), (i == 3) ? 1 : 0);
        end
        idle();

`ifdef TOD_COUNTER_ALARM_EN
        alarm_set = 1'b1; alarm_hours = 5'd7; alarm_minutes = 6'd15; cycle(); idle();
        load2(2'b01, 7, 14, 0, 0); cycle(); idle();
        tick = 1'b1; cycle(); idle();
        check("alarm_tick_hit", int'(ah_o[0]), 1);
        cycle();
        check("alarm_one_cycle", int'(ah_o[0]), 0);
        load2(2'b01, 7, 15, 0, 0); cycle(); idle();
        check("alarm_load_no_hit", int'(ah_o[0]), 0);
`endif

        for (int n = 0; n < 1500; n++) begin
            idle();
            reset = ($urandom_range(0, 149) == 0);
            tick  = 1'($urandom_range(0, 1));
            h0  = ($urandom_range(0, 3) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
            h1  = ($urandom_range(0, 3) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
            mi0 = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
            mi1 = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
            if ($urandom_range(0, 9) == 0) load2(2'($urandom_range(1, 3)), h0, mi0, h1, mi1);
            else load2(2'b00, h0, mi0, h1, mi1);
`ifdef TOD_COUNTER_ALARM_EN
            if ($urandom_range(0, 49) == 0) begin
                alarm_set = 1'b1;
                alarm_hours = 5'(h0);
                alarm_minutes = 6'(mi0);
            end
`endif
            cycle();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
